io_port_ctrl: RTL and testbench

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_port_ctrl.sv | 125 ++++++++++++
 tb/tb_io_port_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port controller: LED registers, synchronised switches, debounced buttons with press events.
// Optional button debounce counters are built when IO_DEBOUNCE_EN is defined.
module io_port_ctrl #(
    parameter int DW         = 8,
    parameter int NPORTS     = 4,
    parameter int NBTN       = 4,
    parameter int NSW        = 10,
    parameter int DEB_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(NPORTS)-1:0] io_port,
    input  logic                      we_o,
    input  logic [DW-1:0]             wdata,
    input  logic                      re_i,
    output logic [DW-1:0]             rdata,
    input  logic [NBTN-1:0]           buttons,
    input  logic [NSW-1:0]            switches,
    output logic [DW-1:0]             led_v,
    output logic [NSW-1:0]            led_r,
    output logic                      btn_evt
);

    localparam int AW = $clog2(NPORTS);

    logic [NBTN-1:0] btn_s1, btn_s2;
    logic [NSW-1:0]  sw_s1, sw_s2;
    logic [NBTN-1:0] db;
    logic [NBTN-1:0] db_q;
    logic [NBTN-1:0] evt;
    logic [NBTN-1:0] rise;
    logic [DW-1:0]   rd_mux;
    logic            rd_evt;

    // Buttons are stored active-high so the all-zero reset state means "released".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= ~buttons;
            btn_s2 <= btn_s1;
            sw_s1  <= switches;
            sw_s2  <= sw_s1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);

    for (genvar g = 0; g < NBTN; g++) begin : g_deb
        logic [CW-1:0] cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt   <= '0;
                db[g] <= 1'b0;
            end else if (btn_s2[g] != db[g]) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    db[g] <= btn_s2[g];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
`else
    assign db = btn_s2;
`endif

    assign rise   = db & ~db_q;
    assign rd_evt = re_i && (io_port == AW'(2));

    // A press landing on the clearing read survives because rise is ORed in after the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q <= '0;
            evt  <= '0;
        end else begin
            db_q <= db;
            evt  <= (rd_evt ? '0 : evt) | rise;
        end
    end

    assign btn_evt = |evt;

    always_comb begin
        rd_mux = '0;
        case (io_port)
            AW'(0):  rd_mux[NBTN-1:0]     = db;
            AW'(1):  rd_mux               = sw_s2[DW-1:0];
            AW'(2):  rd_mux[NBTN-1:0]     = evt;
            AW'(3):  rd_mux[NSW-DW-1:0]   = sw_s2[NSW-1:DW];
            default: rd_mux               = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re_i) begin
            rdata <= rd_mux;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_v <= '0;
            led_r <= '0;
        end else if (we_o) begin
            case (io_port)
                AW'(0):  led_v            <= wdata;
                AW'(1):  led_r[DW-1:0]    <= wdata;
                AW'(3):  led_r[NSW-1:DW]  <= wdata[NSW-DW-1:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed self-checking bench for io_port_ctrl; expected latencies follow IO_DEBOUNCE_EN.
module tb_io_port_ctrl;

    localparam int DEB = 16;
`ifdef IO_DEBOUNCE_EN
    localparam int DL = 2 + DEB;
`else
    localparam int DL = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] io_port = '0;
    logic       we_o = 1'b0;
    logic [7:0] wdata = '0;
    logic       re_i = 1'b0;
    logic [7:0] rdata;
    logic [3:0] buttons = 4'hF;
    logic [9:0] switches = '0;
    logic [7:0] led_v;
    logic [9:0] led_r;
    logic       btn_evt;

    int checks = 0;
    int failures = 0;

    io_port_ctrl #(
        .DW(8), .NPORTS(8), .NBTN(4), .NSW(10), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .io_port(io_port), .we_o(we_o), .wdata(wdata),
        .re_i(re_i), .rdata(rdata), .buttons(buttons), .switches(switches),
        .led_v(led_v), .led_r(led_r), .btn_evt(btn_evt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] p, input logic [7:0] d);
        io_port = p;
        wdata   = d;
        we_o    = 1'b1;
        tick(1);
        we_o    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] p);
        io_port = p;
        re_i    = 1'b1;
        tick(1);
        re_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_led_v", 16'(led_v), 16'h0);
        chk("rst_led_r", 16'(led_r), 16'h0);
        chk("rst_rdata", 16'(rdata), 16'h0);
        chk("rst_btn_evt", 16'(btn_evt), 16'h0);
        reset = 1'b1;

        wr(3'd1, 8'h3C);
        wr(3'd0, 8'hA5);
        wr(3'd3, 8'hFF);
        chk("wr_led_v", 16'(led_v), 16'h00A5);
        chk("wr_led_r", 16'(led_r), 16'h033C);

        switches = 10'h2C3;
        tick(2);
        rd(3'd1);
        chk("rd_sw_lo", 16'(rdata), 16'h00C3);
        tick(2);
        chk("rd_hold", 16'(rdata), 16'h00C3);
        rd(3'd3);
        chk("rd_sw_hi", 16'(rdata), 16'h0002);

        wr(3'd2, 8'h55);
        wr(3'd5, 8'h77);
        chk("ign_led_v", 16'(led_v), 16'h00A5);
        chk("ign_led_r", 16'(led_r), 16'h033C);
        chk("ign_btn_evt", 16'(btn_evt), 16'h0);
        rd(3'd5);
        chk("rd_port5", 16'(rdata), 16'h0000);

        io_port = 3'd1;
        wdata   = 8'h5A;
        we_o    = 1'b1;
        re_i    = 1'b1;
        tick(1);
        we_o    = 1'b0;
        re_i    = 1'b0;
        chk("rw_rdata", 16'(rdata), 16'h00C3);
        chk("rw_led_r", 16'(led_r), 16'h035A);
        rd(3'd2);
        chk("rd_evt_idle", 16'(rdata), 16'h0000);

        // Press button 1 and pin the exact debounce and event latency.
        buttons = 4'b1101;
        tick(DL - 1);
        chk("press_evt_early", 16'(btn_evt), 16'h0);
        rd(3'd0);
        chk("press_db_early", 16'(rdata), 16'h0000);
        chk("press_evt_at_db", 16'(btn_evt), 16'h0);
        rd(3'd0);
        chk("press_db", 16'(rdata), 16'h0002);
        chk("press_evt", 16'(btn_evt), 16'h1);

        rd(3'd2);
        chk("evt_rd", 16'(rdata), 16'h0002);
        chk("evt_cleared", 16'(btn_evt), 16'h0);
        rd(3'd2);
        chk("evt_rd_empty", 16'(rdata), 16'h0000);

        buttons = 4'hF;
        tick(DL + 2);
        chk("release_no_evt", 16'(btn_evt), 16'h0);

        buttons = 4'b1101;
        tick(DL + 1);
        chk("repress_evt", 16'(btn_evt), 16'h1);
        buttons = 4'b1001;
        tick(DL);
        rd(3'd2);
        chk("coinc_rd", 16'(rdata), 16'h0002);
        chk("coinc_evt_kept", 16'(btn_evt), 16'h1);
        rd(3'd2);
        chk("coinc_rd2", 16'(rdata), 16'h0004);
        chk("coinc_cleared", 16'(btn_evt), 16'h0);

        buttons = 4'hF;
        tick(DL + 2);
`ifdef IO_DEBOUNCE_EN
        buttons = 4'b1110;
        tick(10);
        buttons = 4'hF;
        tick(DL + 4);
        chk("glitch_evt", 16'(btn_evt), 16'h0);
        rd(3'd0);
        chk("glitch_db", 16'(rdata), 16'h0000);
        rd(3'd2);
        chk("glitch_evt_bits", 16'(rdata), 16'h0000);
`endif

        wr(3'd0, 8'hFF);
        wr(3'd1, 8'hFF);
        wr(3'd3, 8'hFF);
        chk("pre_rst_led_r", 16'(led_r), 16'h03FF);
        rd(3'd1);
        chk("pre_rst_rdata", 16'(rdata), 16'h00C3);
        buttons = 4'b1110;
        tick(DL + 1);
        chk("pre_rst_evt", 16'(btn_evt), 16'h1);
        buttons = 4'b0110;
        tick(DL / 2);
        reset = 1'b0;
        #1;
        chk("arst_led_v", 16'(led_v), 16'h0);
        chk("arst_led_r", 16'(led_r), 16'h0);
        chk("arst_rdata", 16'(rdata), 16'h0);
        chk("arst_btn_evt", 16'(btn_evt), 16'h0);
        tick(2);
        reset = 1'b1;
        tick(DL);
        chk("post_rst_evt_early", 16'(btn_evt), 16'h0);
        tick(1);
        chk("post_rst_evt", 16'(btn_evt), 16'h1);
        rd(3'd2);
        chk("post_rst_evt_bits", 16'(rdata), 16'h0009);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
